fp_mat_fetch: RTL and testbench

FP_MAT_FETCH -- requirements
Module: fp_mat_fetch

---
 rtl/fp_mat_fetch.sv | 149 ++++++++++++++
 tb/tb_fp_mat_fetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mat_fetch.sv
// Matrix fetch engine: a custom instruction starts an Avalon burst of N*N word reads into a
// local buffer, optionally summing all / diagonal elements, with the result returned over a slave port.
module fp_mat_fetch #(
    parameter int ADDR_WIDTH  = 24,
    parameter int MAX_DIM     = 32,
    parameter int DEFAULT_DIM = 16,
    parameter int MAX_PENDING = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           dataa,
    input  logic [31:0]           datab,
    output logic [31:0]           result,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read,
    input  logic [31:0]           readdata,
    input  logic                  readdatavalid,
    input  logic                  waitrequest,
    input  logic [9:0]            buf_rdaddr,
    output logic [31:0]           buf_rddata,
    input  logic                  result_read,
    output logic [31:0]           result_readdata,
    output logic                  irq,
    output logic [1:0]            dbgState
);
    localparam int DEPTH  = MAX_DIM * MAX_DIM;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int BUF_AW = $clog2(DEPTH);

    // Handshake: a read request is accepted on a cycle with read && !waitrequest; while
    // waitrequest is high, read and address hold; each readdatavalid returns one word in order.
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, HOLD = 2'd3} state_t;

    state_t                state, stateNext;
    logic [ADDR_WIDTH-1:0] base;
    logic [CW-1:0]         nSq, diagStep, nextDiag;
    logic [CW-1:0]         issued, received;
    logic [3:0]            pending;
    logic                  modeSum, diagSel;
    logic [31:0]           sumAll, sumDiag;
    logic [31:0]           mem [0:DEPTH-1];

    logic [7:0]  cmdDim, effDim;
    logic        isProbe, isReject, launch, accept, take;
    logic [31:0] statusWord, readout;
    logic        unusedBits;

    assign unusedBits = ^{dataa[31:ADDR_WIDTH], datab[31:10]};
    assign dbgState   = state;
    assign statusWord = {30'd0, state};
    assign readout    = modeSum ? (diagSel ? sumDiag : sumAll) : 32'(nSq);

    assign cmdDim   = datab[7:0];
    assign effDim   = (cmdDim == 8'd0) ? 8'(DEFAULT_DIM) : cmdDim;
    assign isProbe  = (cmdDim == 8'd1);
    assign isReject = (int'(cmdDim) > MAX_DIM);
    assign launch   = start && (state == IDLE) && !isProbe && !isReject;

    assign read    = (state == FETCH) && (issued < nSq) && (pending < 4'(MAX_PENDING));
    assign address = base + (ADDR_WIDTH'(issued) << 2);
    assign accept  = read && !waitrequest;
    // Responses outside an active transfer (e.g. stragglers after a reset) are dropped here.
    assign take    = readdatavalid && ((state == FETCH) || (state == DRAIN)) && (received < nSq);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (launch) stateNext = FETCH;
            FETCH:   if (accept && (issued == nSq - CW'(1))) stateNext = DRAIN;
            DRAIN:   if ((received == nSq) || (take && (received == nSq - CW'(1)))) stateNext = HOLD;
            HOLD:    if (result_read) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            done            <= 1'b0;
            result          <= 32'd0;
            result_readdata <= 32'd0;
            irq             <= 1'b0;
            base            <= '0;
            nSq             <= '0;
            diagStep        <= '0;
            nextDiag        <= '0;
            issued          <= '0;
            received        <= '0;
            pending         <= '0;
            modeSum         <= 1'b0;
            diagSel         <= 1'b0;
            sumAll          <= 32'd0;
            sumDiag         <= 32'd0;
        end else begin
            state  <= stateNext;
            done   <= start;
            result <= 32'd0;
            if (start) begin
                if (state != IDLE)  result <= statusWord;
                else if (isProbe)   result <= 32'hFFFF_FFFF;
                else if (isReject)  result <= 32'hFFFF_FFFE;
                else                result <= 32'd99;
            end

            if (launch) begin
                base     <= dataa[ADDR_WIDTH-1:0];
                nSq      <= CW'(effDim) * CW'(effDim);
                diagStep <= CW'(effDim) + CW'(1);
                modeSum  <= datab[8];
                diagSel  <= datab[9];
                nextDiag <= '0;
                issued   <= '0;
                received <= '0;
                pending  <= '0;
                sumAll   <= 32'd0;
                sumDiag  <= 32'd0;
            end

            if (accept) issued <= issued + CW'(1);
            if (accept && !take)      pending <= pending + 4'd1;
            else if (!accept && take) pending <= pending - 4'd1;

            if (take) begin
                received <= received + CW'(1);
                if (modeSum) begin
                    sumAll <= sumAll + readdata;
                    if (received == nextDiag) begin
                        sumDiag  <= sumDiag + readdata;
                        nextDiag <= nextDiag + diagStep;
                    end
                end
            end

            if ((state == DRAIN) && (stateNext == HOLD)) irq <= 1'b1;
            else if ((state == HOLD) && result_read)     irq <= 1'b0;

            result_readdata <= 32'd0;
            if (result_read) result_readdata <= (state == HOLD) ? readout : statusWord;
        end
    end

    // Buffer is deliberately outside reset so contents survive until overwritten.
    always_ff @(posedge clk) begin
        if (take) mem[received[BUF_AW-1:0]] <= readdata;
        buf_rddata <= mem[buf_rdaddr];
    end
endmodule

// File: tb/tb_fp_mat_fetch.sv
// Bench for fp_mat_fetch: table of IDLE commands plus hand-written fetch sequences against a
// latency/stall-configurable Avalon slave model.
module tb_fp_mat_fetch;
  localparam int AW   = 24;
  localparam int MAXP = 8;

  logic          clk, reset, start, read, readdatavalid, waitrequest, done, irq, result_read;
  logic [31:0]   dataa, datab, result, readdata, buf_rddata, result_readdata;
  logic [AW-1:0] address;
  logic [9:0]    buf_rdaddr;
  logic [1:0]    dbgState;

  fp_mat_fetch dut (
    .clk(clk), .reset(reset), .start(start), .dataa(dataa), .datab(datab),
    .result(result), .done(done), .address(address), .read(read),
    .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest),
    .buf_rdaddr(buf_rdaddr), .buf_rddata(buf_rddata), .result_read(result_read),
    .result_readdata(result_readdata), .irq(irq), .dbgState(dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_done_q[$];
  logic [31:0] exp_rr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // slave model state
  typedef struct { int due; logic [31:0] data; } resp_t;
  resp_t         respQ[$];
  logic [AW-1:0] tbBase = '0;
  logic [AW-1:0] lastAddr;
  int latency = 2, waitPct = 0, strays = 0, cyc = 0;
  int accCount = 0, retCount = 0, outstanding = 0, maxOut = 0;
  logic acceptNow = 0, rdvNow = 0, lastStall = 0;

  function automatic logic [31:0] word_at(input logic [AW-1:0] a);
    return 32'((a - tbBase) >> 2) + 32'd1;
  endfunction

  task automatic slave_step();
    resp_t r;
    if (acceptNow) begin accCount++; outstanding++; end
    if (rdvNow) begin retCount++; if (outstanding > 0) outstanding--; end
    if (outstanding > maxOut) maxOut = outstanding;
    acceptNow = 0;
    rdvNow = 0;
    if (lastStall) begin
      chk("stall_read", 32'(read), 32'd1);
      chk("stall_addr", 32'(address), 32'(lastAddr));
    end
    if (read === 1'b1) chk("pending_cap", 32'(outstanding < MAXP), 32'd1);
    waitrequest = (waitPct > 0) && ($urandom_range(99) < waitPct);
    lastStall = (read === 1'b1) && waitrequest;
    lastAddr = address;
    if ((read === 1'b1) && !waitrequest) begin
      chk("addr_seq", 32'(address), 32'(tbBase + AW'(4 * accCount)));
      acceptNow = 1;
      respQ.push_back('{cyc + latency, word_at(address)});
    end
    readdatavalid = 1'b0;
    readdata = $urandom;
    if (strays > 0) begin
      readdatavalid = 1'b1;
      readdata = 32'hDEAD_0000 | 32'(strays);
      strays--;
    end else if (respQ.size() > 0 && respQ[0].due <= cyc) begin
      r = respQ.pop_front();
      readdatavalid = 1'b1;
      readdata = r.data;
      rdvNow = 1;
    end
    cyc++;
  endtask

  // scoreboard: inputs still hold what the last posedge sampled
  task automatic monitor_step();
    logic [31:0] e;
    if (reset) return;
    if (start) begin
      chk("done_hi", 32'(done), 32'd1);
      if (exp_done_q.size() == 0) chk("done_q_empty", 32'd1, 32'd0);
      else begin e = exp_done_q.pop_front(); chk("result", result, e); end
    end else begin
      chk("done_lo", 32'(done), 32'd0);
      chk("result_zero", result, 32'd0);
    end
    if (result_read) begin
      if (exp_rr_q.size() == 0) chk("rr_q_empty", 32'd1, 32'd0);
      else begin e = exp_rr_q.pop_front(); chk("result_readdata", result_readdata, e); end
    end else begin
      chk("rr_zero", result_readdata, 32'd0);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
    slave_step();
    monitor_step();
    start = 1'b0;
    result_read = 1'b0;
  endtask

  task automatic cmd(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    start = 1'b1;
    dataa = a;
    datab = b;
    exp_done_q.push_back(exp);
    tick();
  endtask

  task automatic rd_res(input logic [31:0] exp);
    result_read = 1'b1;
    exp_rr_q.push_back(exp);
    tick();
  endtask

  task automatic new_fetch(input logic [AW-1:0] b, input int lat);
    tbBase = b;
    latency = lat;
    accCount = 0;
    retCount = 0;
    maxOut = 0;
  endtask

  task automatic wait_irq(input int budget);
    for (int i = 0; i < budget && irq !== 1'b1; i++) tick();
    chk("irq_wait", 32'(irq), 32'd1);
    chk("hold_state", 32'(dbgState), 32'd3);
  endtask

  task automatic buf_chk(input logic [9:0] a, input logic [31:0] exp);
    buf_rdaddr = a;
    tick();
    chk("buf_word", buf_rddata, exp);
  endtask

  typedef struct { logic [31:0] b; logic [31:0] exp; } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF};
    vecs[1] = '{32'h0000_0101, 32'hFFFF_FFFF};
    vecs[2] = '{32'h0000_0021, 32'hFFFF_FFFE};
    vecs[3] = '{32'h0000_0028, 32'hFFFF_FFFE};
    vecs[4] = '{32'h0000_00FF, 32'hFFFF_FFFE};
    vecs[5] = '{32'h0000_0321, 32'hFFFF_FFFE};

    reset = 1'b1; start = 1'b0; dataa = '0; datab = '0; result_read = 1'b0;
    readdatavalid = 1'b0; readdata = '0; waitrequest = 1'b0; buf_rdaddr = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rrdata", result_readdata, 32'd0);
    chk("rst_state", 32'(dbgState), 32'd0);

    // probes and rejects never leave IDLE
    for (int i = 0; i < 6; i++) begin
      cmd($urandom, vecs[i].b, vecs[i].exp);
      chk("idle_stays", 32'(dbgState), 32'd0);
      chk("idle_no_read", 32'(read), 32'd0);
    end
    rd_res(32'd0);

    // N=3 sum, with status queries mid-transfer
    new_fetch(24'h001000, 2);
    cmd(32'h0000_1000, 32'h0000_0103, 32'd99);
    chk("fetch_state", 32'(dbgState), 32'd1);
    cmd(32'h0, 32'h5, 32'd1);
    rd_res(32'd1);
    wait_irq(200);
    chk("n3_reqs", 32'(accCount), 32'd9);
    cmd(32'h0, 32'h0, 32'd3);
    rd_res(32'd45);
    chk("irq_clear", 32'(irq), 32'd0);
    chk("back_idle", 32'(dbgState), 32'd0);
    buf_chk(10'd4, 32'd5);
    buf_chk(10'd8, 32'd9);

    new_fetch(24'h002000, 2);
    cmd(32'h0000_2000, 32'h0000_0303, 32'd99);
    wait_irq(200);
    rd_res(32'd15);

    new_fetch(24'h002400, 2);
    cmd(32'h0000_2400, 32'h0000_0003, 32'd99);
    wait_irq(200);
    rd_res(32'd9);

    // N=32 with slow slave: outstanding reads must cap at MAX_PENDING
    new_fetch(24'h010000, 20);
    cmd(32'h0001_0000, 32'h0000_0120, 32'd99);
    wait_irq(20000);
    chk("n32_reqs", 32'(accCount), 32'd1024);
    chk("max_pending", 32'(maxOut), 32'(MAXP));
    rd_res(32'd524800);
    buf_chk(10'd1023, 32'd1024);
    buf_chk(10'd0, 32'd1);

    // random waitrequest stalls
    new_fetch(24'h020000, 3);
    waitPct = 50;
    cmd(32'h0002_0000, 32'h0000_0104, 32'd99);
    wait_irq(2000);
    waitPct = 0;
    chk("n4_reqs", 32'(accCount), 32'd16);
    rd_res(32'd136);

    // reset mid-transfer, then stray responses in IDLE
    new_fetch(24'h030000, 3);
    cmd(32'h0003_0000, 32'h0000_0104, 32'd99);
    for (int i = 0; i < 200 && retCount < 5; i++) tick();
    chk("five_returned", 32'(retCount), 32'd5);
    reset = 1'b1;
    respQ.delete();
    acceptNow = 0; rdvNow = 0; outstanding = 0; lastStall = 0;
    tick();
    reset = 1'b0;
    chk("mid_rst_state", 32'(dbgState), 32'd0);
    chk("mid_rst_read", 32'(read), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    strays = 3;
    repeat (5) tick();
    chk("stray_state", 32'(dbgState), 32'd0);
    buf_chk(10'd0, 32'd1);
    buf_chk(10'd4, 32'd5);

    new_fetch(24'h040000, 2);
    cmd(32'h0004_0000, 32'h0000_0102, 32'd99);
    wait_irq(200);
    rd_res(32'd10);
    buf_chk(10'd3, 32'd4);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
